mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle HI/LO arithmetic unit in the EX stage. Executes mult, multu, div, divu, madd, maddu, msub and msubu, and the mul product path. Stalls the pipeline via `busy_o` while it works, and returns a registered 64-bit {HI, LO} result with a one-cycle `done_o` pulse. It acts on the is_mult/is_div/hilo-write requests that the ID-stage decode produces.

## Interface
Parameters:
- none. The datapath is fixed at 32-bit operands and a 64-bit result.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  request from EX. Sampled only in IDLE.
- `op_i`  in  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
- `a_i`  in  32  rs operand; the dividend for divide operations.
- `b_i`  in  32  rt operand; the divisor for divide operations.
- `hi_i`, `lo_i`  in  32 each  current forwarded HI/LO, used for accumulate operations.
- `flush_i`  in  1  cancels any accepted or in-flight operation (exception/eret).
- `busy_o`  out  1  stall request to the hazard unit.
- `done_o`  out  1  one-cycle pulse; `hi_o`/`lo_o` are valid in this cycle.
- `hi_o`, `lo_o`  out  32 each  registered result. Held until the next `done_o`.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: `start_i & !flush_i` latches `op_i`, the operands and `hi_i`/`lo_i`.
    - Multiply and accumulate ops go to MUL.
    - Divide ops go to DIV, with the iteration counter cleared.
  - MUL: computes the 64-bit product (signed for op[0]=0, unsigned for op[0]=1).
    - Then: mult/multu gives {HI,LO} = product; madd* gives {hi,lo}_latched + product; msub* gives {hi,lo}_latched − product.
    - All arithmetic is mod 2^64.
    - Writes the result registers and goes to DONE.
  - DIV: restoring division, one quotient bit per cycle, 32 cycles on magnitudes.
    - Signed ops take |a| and |b|.
    - On the last iteration the sign fix is applied: quotient negated iff the operand signs differ; remainder takes the dividend's sign.
    - LO = quotient, HI = remainder, written into the result registers, then go to DONE.
  - DONE: `done_o` = 1, then return to IDLE. `start_i` is ignored here, because the same instruction is still in EX.
- Divide by zero (div or divu): LO = 32'hFFFFFFFF, HI = latched a. Latency is unchanged. No exception is raised.
- Signed overflow 0x80000000 / −1: LO = 0x80000000, HI = 0.
- `busy_o` = (IDLE & `start_i` & !`flush_i`) | MUL | DIV. It is combinational so EX stalls in the accept cycle.
- `flush_i` in MUL, DIV or DONE: next state is IDLE. `done_o` is suppressed and the result registers are not written. `flush_i` wins over `start_i` in IDLE.
- Forwarding into `hi_i`/`lo_i` is the pipeline's job. The unit samples them once, in the accept cycle.

## Timing
- Accept in cycle t.
- Multiply ops:
  - MUL state in t+1.
  - `done_o` in t+2.
  - `busy_o` high in t and t+1 (2 stall cycles).
- Divide ops:
  - DIV state in t+1..t+32 (counter 0..31).
  - `done_o` in t+33.
  - `busy_o` high in t..t+32 (33 cycles).
- `hi_o`/`lo_o` change only on the edge that enters DONE.
- Back-to-back operations: a new accept is possible in the cycle after DONE.
- Reset:
  - state = IDLE, counter = 0.
  - `hi_o` = `lo_o` = 0, `done_o` = 0.
  - `busy_o` is forced to 0 while `rst` is high.
  - Reset asserted mid-operation takes effect immediately and discards the operation.

## Structure
- The op_i encoding constants and the FSM state encodings go in the shared defines header, alongside the existing opcode/funct macros.
- The EX-stage op encoder uses the same header.
- Sub-module `div_radix2`: the 32-iteration restoring core.
  - Inputs: start, magnitudes.
  - Outputs: quotient, remainder, last-iteration flag.
  - Instantiated once.
- The multiplier is an inline 33×33 signed multiply, registered in MUL.

## Test plan
- mult, a=0xFFFFFFFF, b=2 → `done_o` at t+2, HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div, a=0xFFFFFFF9 (−7), b=2 → `busy_o` high exactly 33 cycles, `done_o` at t+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7/0 → LO=0xFFFFFFFF, HI=7. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- madd with hi_i=0, lo_i=0xFFFFFFFF, a=b=1 → HI=1, LO=0. msubu with hi_i=lo_i=0, a=b=1 → HI=LO=0xFFFFFFFF.
- div with `flush_i` at t+10 → IDLE at t+11, no `done_o`, HI/LO keep their previous values. `start_i` held high through DONE → exactly one `done_o`.
- `rst` pulsed at t+5 of a div → `busy_o`=0, `hi_o`=`lo_o`=0 in the same cycle. Next accept after reset completes normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the op_i encoding, the FSM state encoding and small helpers used by
// both the unit and the EX-stage op encoder.
package mul_div_unit_pkg;

  // op_i encoding: bit0 = unsigned, bit[2:1] = 00 mul, 01 div, 10 madd, 11 msub
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam int DIV_ITERS = 32;

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  // Magnitude of a 32-bit value; only negates when treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_radix2.sv
// div_radix2: 32-iteration restoring divider core on unsigned magnitudes.
// Ports:
//   clk, rst              clock, async active-high reset
//   start_i               load dividend/divisor magnitudes, clear counter
//   dividend_i/divisor_i  unsigned magnitudes
//   quo_o/rem_o           quotient/remainder after the current iteration
//   last_o                current cycle is the final (32nd) iteration
module div_radix2
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        last_o
);

  localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;   // shifts dividend out the top, quotient in the bottom
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    ge     = rem_sh >= {1'b0, dvs_q};
    // When ge holds the true difference is below 2^32, so 32-bit subtract suffices.
    rem_nx = ge ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
    quo_nx = {quo_q[30:0], ge};

    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q + 5'd1;
      run_d = (cnt_q != LAST_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign quo_o  = quo_nx;
  assign rem_o  = rem_nx;
  assign last_o = run_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO arithmetic unit for the EX stage.
// Executes mult/multu/div/divu/madd/maddu/msub/msubu and returns a registered
// {HI,LO} result with a one-cycle done pulse.
// Ports:
//   clk, rst          clock, async active-high reset
//   start_i, op_i     request and operation (sampled in IDLE only)
//   a_i, b_i          rs/rt operands (dividend/divisor for divides)
//   hi_i, lo_i        forwarded HI/LO for accumulate ops
//   flush_i           cancels accepted/in-flight operation
//   busy_o            stall request, combinational
//   done_o            result valid pulse
//   hi_o, lo_o        registered result, held until next done
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e   state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic accept, div_start, sgn_in;
  assign accept    = (state_q == ST_IDLE) && start_i && !flush_i;
  assign div_start = accept && is_div_op(op_i);
  assign sgn_in    = !op_i[0];

  logic [31:0] div_quo, div_rem;
  logic        div_last;

  div_radix2 u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (mag32(a_i, sgn_in)),
    .divisor_i  (mag32(b_i, sgn_in)),
    .quo_o      (div_quo),
    .rem_o      (div_rem),
    .last_o     (div_last)
  );

  // 33x33 signed multiply: the extra top bit is the sign for signed ops, 0 otherwise.
  logic signed [32:0] mul_a, mul_b;
  logic [63:0] prod, mul_res;
  assign mul_a = {!op_q[0] && a_q[31], a_q};
  assign mul_b = {!op_q[0] && b_q[31], b_q};
  assign prod  = 64'(mul_a * mul_b);

  always_comb begin
    unique case (op_q[2:1])
      2'b10:   mul_res = acc_q + prod;
      2'b11:   mul_res = acc_q - prod;
      default: mul_res = prod;
    endcase
  end

  // Sign fix-up: quotient negative iff signs differ, remainder follows dividend.
  logic        div_sgn;
  logic [31:0] div_lo, div_hi;
  assign div_sgn = !op_q[0];
  always_comb begin
    if (b_q == 32'd0) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = a_q;
    end else begin
      div_lo = (div_sgn && (a_q[31] ^ b_q[31])) ? (~div_quo + 32'd1) : div_quo;
      div_hi = (div_sgn && a_q[31]) ? (~div_rem + 32'd1) : div_rem;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = {hi_i, lo_i};
          state_d = is_div_op(op_i) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          {hi_d, lo_d} = mul_res;
          state_d      = ST_DONE;
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (div_last) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = !rst && (accept || state_q == ST_MUL || state_q == ST_DIV);
  assign done_o = (state_q == ST_DONE) && !flush_i;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, scoreboard queue
// filled at issue time and drained by an independent done_o monitor.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = '0, b_i = '0, hi_i = '0, lo_i = '0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   tag_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pops one expected result.
  always @(negedge clk) begin
    #1;
    if (!rst && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected no done", hi_o, lo_o);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("result_%0d", mon_e.tag), {hi_o, lo_o}, {mon_e.hi, mon_e.lo});
      end
    end
  end

  // Issue one op; checks done latency and busy cycle count (both equal lat).
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input bit hold);
    exp_t x;
    int   cyc;
    int   nb;
    bit   seen;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; hi_i = hi; lo_i = lo;
    x.hi = eh; x.lo = el; x.tag = tag_cnt;
    tag_cnt++;
    sb.push_back(x);
    cyc = 0; nb = 0; seen = 1'b0;
    #1;
    while (!seen && cyc <= 60) begin
      if (busy_o) nb++;
      if (done_o) seen = 1'b1;
      else begin
        @(negedge clk);
        if (!hold) start_i = 1'b0;
        cyc++;
        #1;
      end
    end
    start_i = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected done at %0d", name, cyc, lat);
    end else begin
      check({name, "_lat"}, 64'(cyc), 64'(lat));
      check({name, "_busy"}, 64'(nb), 64'(lat));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: busy forced low even with a request present.
    start_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_done", 64'(done_o), 64'd0);

    run_op("mult",  3'b000, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b0);
    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'h00000001, 32'hFFFFFFFE, 2, 1'b0);
    run_op("div_n7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    run_op("divu_7_0", 3'b011, 32'd7, 32'd0, 32'd0, 32'd0, 32'd7, 32'hFFFFFFFF, 33, 1'b0);
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'h80000000, 33, 1'b0);
    run_op("div_n7_0", 3'b010, 32'hFFFFFFF9, 32'd0, 32'd0, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33, 1'b0);
    run_op("div_7_n2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFD, 33, 1'b0);
    run_op("madd",  3'b100, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 2, 1'b0);
    run_op("msubu", 3'b111, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b0);
    run_op("msub",  3'b110, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd16, 32'd0, 32'd22, 2, 1'b0);
    run_op("maddu", 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFE, 32'h00000001, 2, 1'b0);
    // start held through DONE: exactly one done (monitor flags extras)
    run_op("mult_hold", 3'b000, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd12, 2, 1'b1);
    repeat (4) @(negedge clk);

    // Flush a divide at t+10: idle at t+11, no done, result unchanged.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b010; a_i = 32'd100; b_i = 32'd3;
    #1;
    check("flush_accept_busy", 64'(busy_o), 64'd1);
    repeat (10) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_idle_busy", 64'(busy_o), 64'd0);
    repeat (40) @(negedge clk);
    #1;
    check("flush_hilo_kept", {hi_o, lo_o}, {32'd0, 32'd12});

    // Reset at t+5 of a divide: immediate effect.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b010; a_i = 32'hFFFFFFF9; b_i = 32'd2;
    repeat (5) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("divu_after_rst", 3'b011, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, 33, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
